// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-expansion engine: S-box, schedule sizing,
// GF(2^8) doubling and the key-length legality check.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Total schedule words for a key of nk words (Nr = nk + 6).
    function automatic int nw_words(input int nk);
        return 4 * (nk + 7);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: the AES S-box applied to each byte of a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign sub[8*gi +: 8] = sbox(word[8*gi +: 8]);
    end

endmodule

// File: rtl/key_schedule.sv
// Sequential AES key expansion: loads Nk key words, then writes one schedule
// word per clock until all 4*(Nr+1) words are held on the flat keys bus.
module key_schedule
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [0:Nk*32-1]        key,
    output logic                    busy,
    output logic                    done,
    output logic [0:128*(Nr+1)-1]   keys
);

    localparam int Nw = nw_words(Nk);
    localparam int IW = $clog2(Nw + 1);
    localparam logic [IW-1:0] NK_W    = IW'(Nk);
    localparam logic [IW-1:0] NW_LAST = IW'(Nw - 1);
    localparam logic [2:0]    NK_LAST = 3'(Nk - 1);

    if (!nk_legal(Nk)) begin : g_bad_nk
        $error("key_schedule: Nk must be 4, 6 or 8");
    end
    if (Nr != Nk + 6) begin : g_bad_nr
        $error("key_schedule: Nr must equal Nk + 6");
    end

    ks_state_t       state_reg, state_next;
    logic [IW-1:0]   i_reg, i_next;
    logic [2:0]      imod_reg, imod_next;
    logic [7:0]      rcon_reg, rcon_next;
    logic [31:0]     w_reg [Nw];

    logic            load;
    logic            write_en;
    logic [31:0]     prev_word;
    logic [31:0]     back_word;
    logic [31:0]     rot_word;
    logic [31:0]     sub_in;
    logic [31:0]     sub_out;
    logic [31:0]     temp;
    logic [31:0]     new_word;

    assign prev_word = w_reg[i_reg - 1'b1];
    assign back_word = w_reg[i_reg - NK_W];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    // One S-box bank serves both the rotated (i mod Nk == 0) and plain cases.
    assign sub_in = (imod_reg == 3'd0) ? rot_word : prev_word;

    sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        temp = prev_word;
        if (imod_reg == 3'd0) begin
            temp = sub_out ^ {rcon_reg, 24'h000000};
        end else if (Nk == 8 && imod_reg == 3'd4) begin
            temp = sub_out;
        end
        new_word = back_word ^ temp;
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        imod_next  = imod_reg;
        rcon_next  = rcon_reg;
        load       = 1'b0;
        write_en   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_EXPAND;
                    i_next     = NK_W;
                    imod_next  = 3'd0;
                    rcon_next  = 8'h01;
                end
            end
            ST_EXPAND: begin
                write_en  = 1'b1;
                i_next    = i_reg + 1'b1;
                imod_next = (imod_reg == NK_LAST) ? 3'd0 : imod_reg + 3'd1;
                if (imod_reg == 3'd0) begin
                    rcon_next = xtime(rcon_reg);
                end
                if (i_reg == NW_LAST) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            imod_reg  <= 3'd0;
            rcon_reg  <= 8'h01;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            imod_reg  <= imod_next;
            rcon_reg  <= rcon_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < Nw; j++) begin
                w_reg[j] <= '0;
            end
        end else begin
            if (load) begin
                for (int j = 0; j < Nk; j++) begin
                    w_reg[j] <= key[32*j +: 32];
                end
            end
            if (write_en) begin
                w_reg[i_reg] <= new_word;
            end
        end
    end

    for (genvar gi = 0; gi < Nw; gi++) begin : g_flat
        assign keys[32*gi +: 32] = w_reg[gi];
    end

    assign busy = (state_reg == ST_EXPAND);
    assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: three instances (Nk = 4/6/8), FIPS-197 vectors plus
// random keys, scoreboard compared whenever done rises.
module tb_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
    logic [0:127]  key4 = '0;
    logic [0:191]  key6 = '0;
    logic [0:255]  key8 = '0;
    logic          busy4, busy6, busy8, done4, done6, done8;
    logic [0:1407] keys4;
    logic [0:1663] keys6;
    logic [0:1919] keys8;
    logic [0:1919] keys4_pad, keys6_pad;

    assign keys4_pad = {keys4, 512'b0};
    assign keys6_pad = {keys6, 256'b0};

    key_schedule #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .key(key4),
                                 .busy(busy4), .done(done4), .keys(keys4));
    key_schedule #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .start(start6), .key(key6),
                                 .busy(busy6), .done(done6), .keys(keys6));
    key_schedule #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .key(key8),
                                 .busy(busy8), .done(done8), .keys(keys8));

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [0:127] A1_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_ROUND = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] r, s;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r = inv;
            s = inv;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] r = 8'h01;
        for (int t = 1; t < n; t++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [0:1919] model(input int nk, input logic [0:255] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [0:1919] res = '0;
        int            nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) res[32*i +: 32] = w[i];
        return res;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [0:1919] sched;
        longint        due;
    } exp_t;

    exp_t q4[$], q6[$], q8[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic sb_check(input string name, input int nk, input logic [0:1919] got, input exp_t e);
        int bad = -1;
        int nw = 4 * (nk + 7);
        n_vec++;
        if (cyc != e.due) begin
            n_err++;
            $display("FAIL %s latency: done at cycle %0d, required cycle %0d", name, cyc, e.due);
        end
        n_vec++;
        for (int j = nw - 1; j >= 0; j--) begin
            if (got[32*j +: 32] !== e.sched[32*j +: 32]) bad = j;
        end
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s schedule: w[%0d] got %h, required %h", name, bad,
                     got[32*bad +: 32], e.sched[32*bad +: 32]);
        end else begin
            $display("%s: schedule of %0d words complete at cycle %0d", name, nw, cyc);
        end
    endtask

    task automatic sb_empty(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: done rose with no expansion outstanding (got done=1, required 0)", name);
    endtask

    logic d4q = 1'b0, d6q = 1'b0, d8q = 1'b0;

    always @(negedge clk) begin
        n_vec++;
        if ((busy4 && done4) || (busy6 && done6) || (busy8 && done8)) begin
            n_err++;
            $display("FAIL busy_done_exclusive: busy/done = %b%b %b%b %b%b, required never both",
                     busy4, done4, busy6, done6, busy8, done8);
        end
        if (done4 && !d4q) begin
            if (q4.size() == 0) sb_empty("aes128");
            else sb_check("aes128", 4, keys4_pad, q4.pop_front());
        end
        if (done6 && !d6q) begin
            if (q6.size() == 0) sb_empty("aes192");
            else sb_check("aes192", 6, keys6_pad, q6.pop_front());
        end
        if (done8 && !d8q) begin
            if (q8.size() == 0) sb_empty("aes256");
            else sb_check("aes256", 8, keys8, q8.pop_front());
        end
        d4q = done4;
        d6q = done6;
        d8q = done8;
    end

    // ---------------- stimulus ----------------
    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy4 : (inst == 1) ? busy6 : busy8;
    endfunction

    function automatic logic done_of(input int inst);
        return (inst == 0) ? done4 : (inst == 1) ? done6 : done8;
    endfunction

    // Called at a falling edge; the next rising edge is the start edge E0.
    task automatic start_key(input int inst, input logic [0:255] k, input bit expect_done);
        exp_t e;
        int   nk = 4 + 2 * inst;
        e.sched = model(nk, k);
        e.due   = cyc + 1 + 4 * (nk + 7) - nk;
        case (inst)
            0: begin key4 = k[0:127]; start4 = 1'b1; end
            1: begin key6 = k[0:191]; start6 = 1'b1; end
            default: begin key8 = k; start8 = 1'b1; end
        endcase
        if (expect_done) begin
            case (inst)
                0: q4.push_back(e);
                1: q6.push_back(e);
                default: q8.push_back(e);
            endcase
        end
        $display("start Nk=%0d key=%h", nk, k);
        @(negedge clk);
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        check($sformatf("busy after start Nk=%0d", nk), 128'(busy_of(inst)), 128'd1);
        check($sformatf("done after start Nk=%0d", nk), 128'(done_of(inst)), 128'd0);
    endtask

    task automatic wait_done(input int inst, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = done_of(inst);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout inst %0d: done=0 after %0d cycles, required 1", inst, budget);
        end
    endtask

    initial begin
        logic [0:255] k;
        build_sbox();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset busy4", 128'(busy4), 128'd0);
        check("reset done4", 128'(done4), 128'd0);
        check("reset keys4 nonzero", 128'(|keys4), 128'd0);
        check("reset busy/done Nk=6", {126'd0, busy6, done6}, 128'd0);
        check("reset busy/done Nk=8", {126'd0, busy8, done8}, 128'd0);
        check("reset keys Nk=6/8 nonzero", {126'd0, |keys6, |keys8}, 128'd0);

        // FIPS-197 A.1
        start_key(0, {A1_KEY, 128'h0}, 1'b1);
        wait_done(0, 60);
        check("A1 round 10", keys4[1280 +: 128], A1_ROUND);

        // Back-to-back restart from DONE with the all-zero key
        start_key(0, 256'h0, 1'b1);
        wait_done(0, 60);
        check("zero key w4..7", keys4[128 +: 128], {4{32'h62636363}});

        // FIPS-197 A.2 and A.3
        start_key(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b1);
        wait_done(1, 70);
        check("A2 w48..51", keys6[1536 +: 128], 128'he98ba06f448c773c8ecc720401002202);

        start_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1);
        wait_done(2, 70);
        check("A3 w56..59", keys8[1792 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);

        // start and key changes while busy are ignored
        start_key(0, {A1_KEY, 128'h0}, 1'b1);
        repeat (9) @(negedge clk);
        key4   = {$urandom, $urandom, $urandom, $urandom};
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("busy after ignored start", 128'(busy4), 128'd1);
        wait_done(0, 60);
        check("A1 round 10 after ignored start", keys4[1280 +: 128], A1_ROUND);

        // Asynchronous reset mid-expansion
        k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start_key(0, k, 1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset busy4", 128'(busy4), 128'd0);
        check("mid reset done4", 128'(done4), 128'd0);
        check("mid reset keys4 nonzero", 128'(|keys4), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_key(0, {A1_KEY, 128'h0}, 1'b1);
        wait_done(0, 60);
        check("A1 round 10 after reset", keys4[1280 +: 128], A1_ROUND);

        // Random keys on every key length
        for (int r = 0; r < 4; r++) begin
            for (int inst = 0; inst < 3; inst++) begin
                k = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
                start_key(inst, k, 1'b1);
                wait_done(inst, 70);
            end
        end

        repeat (3) @(negedge clk);
        check("outstanding expansions", 128'(q4.size() + q6.size() + q8.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
